// File: rtl/alu_mdu_pkg.sv
// Shared opcode/state encodings and opcode classification helpers for alu_mdu.
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_XOR   = 4'h3,
    OP_ANDN  = 4'h4,
    OP_ORN   = 4'h5,
    OP_SUB   = 4'h6,
    OP_SLT   = 4'h7,
    OP_SLTU  = 4'h8,
    OP_NOR   = 4'h9,
    OP_MULT  = 4'hA,
    OP_MULTU = 4'hB,
    OP_DIV   = 4'hC,
    OP_DIVU  = 4'hD,
    OP_MFHI  = 4'hE,
    OP_MFLO  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_iter(op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed(op_e op);
    return op inside {OP_MULT, OP_DIV};
  endfunction

  function automatic logic is_div(op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring shift-subtract).
// hi_o/lo_o hold product high/low, or remainder/quotient, after WIDTH steps.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH:0]   sum, shl, diff;

  // One step: acc/mq shift right with conditional add (mul) or left with trial subtract (div).
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, b_q};
    shl   = {acc_q, mq_q[WIDTH-1]};
    diff  = shl - {1'b0, b_q};
    acc_d = acc_q;
    mq_d  = mq_q;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shl[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else if (mq_q[0]) begin
      acc_d = sum[WIDTH:1];
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[WIDTH-1:1]};
      mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
    end
  end

  // Operand load on start, one step per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mq_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mq_q     <= a_i;
      b_q      <= b_i;
      cnt_q    <= '0;
      is_div_q <= is_div_i;
    end else if (en_i) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done_o = en_i && (cnt_q == CNT_W'(WIDTH - 1));
  assign hi_o   = acc_q;
  assign lo_o   = mq_q;

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with handshake and iterative multiply/divide into HI/LO.
//
// state  | meaning
// IDLE   | no result held, ready for a request
// ITER   | mdu_iter stepping a multiply/divide
// FIX    | sign correction, HI/LO written
// DONE   | result held valid until out_ready
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  op_e              op_in;
  state_e           state_q, state_d;
  logic             accept, div_by_zero, start_iter, iter_done;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag, b_add, sum;
  logic [WIDTH-1:0] alu_res, it_hi, it_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic             alu_ovf;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             ovf_q, is_div_q, neg_lo_q, neg_hi_q;

  assign op_in       = op_e'(op);
  assign in_ready    = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept      = in_valid && in_ready;
  assign div_by_zero = is_div(op_in) && (src_b == '0);
  assign start_iter  = accept && is_iter(op_in) && !div_by_zero;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)                   state_d = start_iter ? S_ITER : S_DONE;
        else if (state_q == S_DONE && out_ready) state_d = S_IDLE;
      end
      S_ITER:  if (iter_done) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Single-cycle ALU; divide-by-zero also resolves here to all ones.
  always_comb begin
    b_add   = (op_in == OP_SUB) ? (~src_b + WIDTH'(1)) : src_b;
    sum     = src_a + b_add;
    alu_ovf = 1'b0;
    alu_res = '0;
    case (op_in)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_ovf = (src_a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_ANDN: alu_res = src_a & ~src_b;
      OP_ORN:  alu_res = src_a | ~src_b;
      OP_SLT:  alu_res = WIDTH'($signed(src_a) < $signed(src_b));
      OP_SLTU: alu_res = WIDTH'(src_a < src_b);
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_DIV, OP_DIVU: alu_res = '1;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Signed ops iterate on magnitudes; the sign is restored in FIX.
  always_comb begin
    neg_a = is_signed(op_in) && src_a[WIDTH-1];
    neg_b = is_signed(op_in) && src_b[WIDTH-1];
    a_mag = neg_a ? -src_a : src_a;
    b_mag = neg_b ? -src_b : src_b;
  end

  mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_iter),
    .en_i     (state_q == S_ITER),
    .is_div_i (is_div(op_in)),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .done_o   (iter_done),
    .hi_o     (it_hi),
    .lo_o     (it_lo)
  );

  // Sign correction: product negated as a whole; quotient/remainder individually.
  always_comb begin
    prod     = {it_hi, it_lo};
    prod_neg = -prod;
    if (is_div_q) begin
      fix_lo = neg_lo_q ? -it_lo : it_lo;
      fix_hi = neg_hi_q ? -it_hi : it_hi;
    end else begin
      fix_lo = neg_lo_q ? prod_neg[WIDTH-1:0]       : it_lo;
      fix_hi = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : it_hi;
    end
  end

  // Result, flags and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (start_iter) begin
      ovf_q    <= 1'b0;
      is_div_q <= is_div(op_in);
      neg_lo_q <= neg_a ^ neg_b;
      neg_hi_q <= is_div(op_in) && neg_a;
    end else if (accept) begin
      result_q <= alu_res;
      ovf_q    <= alu_ovf;
      if (div_by_zero) begin
        hi_q <= src_a;
        lo_q <= '1;
      end
    end else if (state_q == S_FIX) begin
      hi_q     <= fix_hi;
      lo_q     <= fix_lo;
      result_q <= fix_lo;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign ovf       = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registers every result and adds signed/unsigned comparison, XOR/NOR, signed overflow, and iterative multiply/divide with architectural HI/LO registers.
- Sits in the execute stage, or behind a multicycle controller.
- The core stalls on in_ready/out_valid while a multiply or divide is iterating.

Parameters:
- WIDTH, 32: operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  operation code (alu_mdu_pkg::op_e).
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result, hi, lo = 0; out_valid=0; ovf=0; in_ready=1 after release. zero is combinational, so reads 1.
- Op codes:
  - 0 AND; 1 OR; 2 ADD; 3 XOR; 4 ANDN (A&~B); 5 ORN (A|~B); 6 SUB.
  - 7 SLT (signed, result 1/0); 8 SLTU (unsigned, result 1/0); 9 NOR.
  - A MULT; B MULTU; C DIV; D DIVU; E MFHI; F MFLO.
- Arithmetic: modulo 2^WIDTH. ovf = sign(A)==sign(B') && sign(res)!=sign(A), where B' = B for ADD and ~B+1 for SUB.
- Handshake:
  - Accept on an edge with in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Back-to-back is allowed: a new accept in DONE coincides with retiring the old result.
  - out_valid, result, zero and ovf hold stable until the edge with out_ready=1.
- FSM IDLE / ITER / FIX / DONE:
  - IDLE or DONE + accept of a single-cycle op (0-9, E, F) -> DONE, result registered at the accept edge. Latency 1.
  - Accept of MULT/MULTU/DIV/DIVU with nonzero divisor (or any multiply) -> ITER. Operands are latched as magnitudes for the signed ops, sign flags saved, cnt=0.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After WIDTH steps -> FIX.
  - FIX: apply sign correction and write {hi,lo} -> DONE. Total latency WIDTH+2 edges from accept to out_valid.
  - DONE + out_ready with no new accept -> IDLE; out_valid falls.
- Mul/div results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product; result = lo.
  - DIV/DIVU: lo = quotient, hi = remainder; result = lo.
  - Signed remainder takes the sign of the dividend; quotient truncates toward zero.
- Boundary cases:
  - Divide by zero: no iteration; accept -> DONE in 1 cycle; lo = all ones, hi = src_a, result = all ones.
  - Signed DIV of MIN by -1: iterate normally; result lo = MIN, hi = 0, no trap.
  - MFHI/MFLO accepted while DONE from a mul/div: read the updated hi/lo, since the write already occurred in FIX.
  - hi/lo change only in FIX or on divide-by-zero.
- Reset mid-ITER aborts the operation: hi/lo return to 0 and no result is produced.
- in_valid while busy: ignored (in_ready=0); the requester must hold it.
- op is sampled only at the accept edge.

Decomposition:
- alu_mdu_pkg: op_e enum (4-bit codes above), state_e enum, localparam helpers (is_iter(op), is_signed(op)).
- One sub-module: mdu_iter. It holds the ITER datapath: accumulator/remainder, shift registers, cnt, one step per enable, and done pulse.
- Top level holds the FSM, the single-cycle ALU case, sign fix and hi/lo.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 -> out_valid one cycle after accept; result 0x80000000; ovf=1; zero=0. Then SUB 5-5 -> result 0, zero=1, ovf=0.
- SLT A=0xFFFFFFFF, B=1 -> 1. SLTU on the same operands -> 0. NOR 0,0 -> 0xFFFFFFFF. ANDN 0xFF,0x0F -> 0xF0.
- MULT -3 * 7 -> out_valid exactly 34 edges after accept (WIDTH=32); hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE. Follow with MFHI -> 1.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7 / 0 -> 1-cycle latency, lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result -> result stable and in_ready=0.
  - Raise out_ready together with a new in_valid ADD -> both handshakes in the same edge; the new result is valid next cycle.
- Assert rst_n=0 asynchronously mid-DIV (cnt=10) -> immediately out_valid=0, hi=lo=0. After release in_ready=1 and a fresh ADD completes correctly.
